seq_addsub16: RTL and testbench

- Nibble-serial 16-bit add/subtract unit for area-constrained datapath paths (address increment, reduction helper).
- Feeds one 4-bit carry-lookahead slice per cycle and holds the inter-nibble carry in a flop.
- Produces a 16-bit result plus N/Z/V flags after 4 cycles through a start/busy/done handshake.
- Result and flags are consumed directly by the flag register and writeback mux.

---
 rtl/seq_addsub16_pkg.sv | 16 +
 rtl/seq_addsub16_nibble_cla_slice.sv | 29 ++
 rtl/seq_addsub16.sv | 132 +++++++++++++
 tb/tb_seq_addsub16.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub16_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package seq_addsub16_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NIBBLES = DATA_W / NIB_W;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/seq_addsub16_nibble_cla_slice.sv
// Combinational 4-bit carry-lookahead slice; exposes the carry into bit 3 for overflow detection.
module seq_addsub16_nibble_cla_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c3,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
        c3   = c[3];
    end

endmodule

// File: rtl/seq_addsub16.sv
// Nibble-serial add/subtract: one 4-bit CLA slice per cycle, result and N/Z/V flags after 4 clocks.
module seq_addsub16
    import seq_addsub16_pkg::*;
#(
    parameter bit          SAT   = 1'b1,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] result_d;
    logic             flag_n_d, flag_z_d, flag_v_d;

    logic [3:0]       slice_a, slice_b, slice_sum;
    logic             slice_c3, slice_cout;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] final_res;
    logic             ovf;

    seq_addsub16_nibble_cla_slice u_nibble_cla_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .c3   (slice_c3),
        .cout (slice_cout)
    );

    // Next-state, datapath and flag logic; the slice always works on nibble cnt_q.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        busy_d    = busy;
        done_d    = 1'b0;
        result_d  = result;
        flag_n_d  = flag_n;
        flag_z_d  = flag_z;
        flag_v_d  = flag_v;

        slice_a   = a_q[{cnt_q, 2'b00} +: 4];
        slice_b   = b_q[{cnt_q, 2'b00} +: 4];
        partial   = result;
        partial[{cnt_q, 2'b00} +: 4] = slice_sum;
        ovf       = slice_cout ^ slice_c3;
        final_res = partial;
        if (SAT && ovf) begin
            final_res = a_q[WIDTH-1] ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                result_d = partial;
                carry_d  = slice_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = final_res;
                    flag_v_d = ovf;
                    flag_n_d = final_res[WIDTH-1];
                    flag_z_d = (final_res == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
            flag_v  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            result  <= result_d;
            flag_n  <= flag_n_d;
            flag_z  <= flag_z_d;
            flag_v  <= flag_v_d;
        end
    end

endmodule

// File: tb/tb_seq_addsub16.sv
// Directed bench for seq_addsub16: saturating and wrapping instances driven in parallel.
module tb_seq_addsub16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;

    logic        busy_s, done_s, n_s, z_s, v_s;
    logic [15:0] res_s;
    logic        busy_w, done_w, n_w, z_w, v_w;
    logic [15:0] res_w;

    int n_cmp = 0;
    int n_bad = 0;

    seq_addsub16 #(.SAT(1'b1), .WIDTH(16)) u_sat (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .result(res_s),
        .flag_n(n_s), .flag_z(z_s), .flag_v(v_s)
    );

    seq_addsub16 #(.SAT(1'b0), .WIDTH(16)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy_w), .done(done_w), .result(res_w),
        .flag_n(n_w), .flag_z(z_w), .flag_v(v_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launch one operation from a negedge; returns at the negedge where done is seen (or budget expires).
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                          output int lat, output int bcnt);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 16'h0; b = 16'h0; sub = 1'b0;
        lat = 0; bcnt = 0;
        while (!done_s && lat < 12) begin
            if (busy_s) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = 16'h0; b = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy_s, done_s, res_s, n_s, z_s, v_s} !== 21'h0) begin
            n_bad++; $display("FAIL reset_sat: got %0h expected 0", {busy_s, done_s, res_s, n_s, z_s, v_s});
        end
        n_cmp++;
        if ({busy_w, done_w, res_w, n_w, z_w, v_w} !== 21'h0) begin
            n_bad++; $display("FAIL reset_wrap: got %0h expected 0", {busy_w, done_w, res_w, n_w, z_w, v_w});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_plain_add();
        int lat, bc;
        run_op(16'h1234, 16'h0FFF, 1'b0, lat, bc);
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL add_latency: got %0d expected 4", lat); end
        n_cmp++;
        if (bc !== 4) begin n_bad++; $display("FAIL add_busy_cycles: got %0d expected 4", bc); end
        n_cmp++;
        if ({done_s, busy_s} !== 2'b10) begin n_bad++; $display("FAIL add_done_busy: got %b expected 10", {done_s, busy_s}); end
        n_cmp++;
        if ({res_s, n_s, z_s, v_s} !== {16'h2233, 3'b000}) begin
            n_bad++; $display("FAIL add_sat: got %0h/%b%b%b expected 2233/000", res_s, n_s, z_s, v_s);
        end
        n_cmp++;
        if ({res_w, n_w, z_w, v_w} !== {16'h2233, 3'b000}) begin
            n_bad++; $display("FAIL add_wrap: got %0h/%b%b%b expected 2233/000", res_w, n_w, z_w, v_w);
        end
        @(negedge clk);
        n_cmp++;
        if ({done_s, res_s} !== {1'b0, 16'h2233}) begin
            n_bad++; $display("FAIL add_hold: got done=%b res=%0h expected done=0 res=2233", done_s, res_s);
        end
    endtask

    task automatic test_zero();
        int lat, bc;
        run_op(16'h0005, 16'h0005, 1'b1, lat, bc);
        n_cmp++;
        if ({res_s, n_s, z_s, v_s} !== {16'h0000, 3'b010}) begin
            n_bad++; $display("FAIL zero_sat: got %0h/%b%b%b expected 0000/010", res_s, n_s, z_s, v_s);
        end
        n_cmp++;
        if ({res_w, n_w, z_w, v_w} !== {16'h0000, 3'b010}) begin
            n_bad++; $display("FAIL zero_wrap: got %0h/%b%b%b expected 0000/010", res_w, n_w, z_w, v_w);
        end
    endtask

    task automatic test_pos_ovf();
        int lat, bc;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat, bc);
        n_cmp++;
        if ({res_s, n_s, z_s, v_s} !== {16'h7FFF, 3'b001}) begin
            n_bad++; $display("FAIL pos_ovf_sat: got %0h/%b%b%b expected 7fff/001", res_s, n_s, z_s, v_s);
        end
        n_cmp++;
        if ({res_w, n_w, z_w, v_w} !== {16'h8000, 3'b101}) begin
            n_bad++; $display("FAIL pos_ovf_wrap: got %0h/%b%b%b expected 8000/101", res_w, n_w, z_w, v_w);
        end
    endtask

    task automatic test_neg_ovf();
        int lat, bc;
        run_op(16'h8000, 16'h0001, 1'b1, lat, bc);
        n_cmp++;
        if ({res_s, n_s, z_s, v_s} !== {16'h8000, 3'b101}) begin
            n_bad++; $display("FAIL neg_ovf_sat: got %0h/%b%b%b expected 8000/101", res_s, n_s, z_s, v_s);
        end
        n_cmp++;
        if ({res_w, n_w, z_w, v_w} !== {16'h7FFF, 3'b001}) begin
            n_bad++; $display("FAIL neg_ovf_wrap: got %0h/%b%b%b expected 7fff/001", res_w, n_w, z_w, v_w);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h0; b = 16'h0;
        lat = 0;
        while (!done_s && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL ignore_latency: got %0d expected 2", lat); end
        n_cmp++;
        if ({res_s, n_s, z_s, v_s} !== {16'h0002, 3'b000}) begin
            n_bad++; $display("FAIL ignore_result: got %0h/%b%b%b expected 0002/000", res_s, n_s, z_s, v_s);
        end
        @(negedge clk);
        n_cmp++;
        if ({done_s, busy_s} !== 2'b00) begin
            n_bad++; $display("FAIL ignore_no_restart: got %b expected 00", {done_s, busy_s});
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(16'h0010, 16'h0020, 1'b0, lat, bc);
        n_cmp++;
        if (res_s !== 16'h0030) begin n_bad++; $display("FAIL b2b_first: got %0h expected 0030", res_s); end
        run_op(16'h0003, 16'h0004, 1'b0, lat, bc);
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
        n_cmp++;
        if ({res_s, n_s, z_s, v_s} !== {16'h0007, 3'b000}) begin
            n_bad++; $display("FAIL b2b_result: got %0h/%b%b%b expected 0007/000", res_s, n_s, z_s, v_s);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int seen;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy_s, done_s, res_s, n_s, z_s, v_s} !== 21'h0) begin
            n_bad++; $display("FAIL midreset_sat: got %0h expected 0", {busy_s, done_s, res_s, n_s, z_s, v_s});
        end
        n_cmp++;
        if ({busy_w, done_w, res_w, n_w, z_w, v_w} !== 21'h0) begin
            n_bad++; $display("FAIL midreset_wrap: got %0h expected 0", {busy_w, done_w, res_w, n_w, z_w, v_w});
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_s || done_w || busy_s) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d activity cycles expected 0", seen); end
        run_op(16'h0001, 16'h0002, 1'b0, lat, bc);
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL after_reset_latency: got %0d expected 4", lat); end
        n_cmp++;
        if ({res_s, n_s, z_s, v_s} !== {16'h0003, 3'b000}) begin
            n_bad++; $display("FAIL after_reset_result: got %0h/%b%b%b expected 0003/000", res_s, n_s, z_s, v_s);
        end
    endtask

    initial begin
        test_reset();
        test_plain_add();
        test_zero();
        test_pos_ovf();
        test_neg_ovf();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
